// File: rtl/fifo_umbral_param_if.sv
// Bus bundle for fifo_umbral_param: write/read requests, threshold programming and status.
// push/pop are single-cycle requests sampled on every rising edge; there is no ready/back-pressure,
// a request the FIFO cannot honour is dropped (RESET/INIT/ERROR) or raises the sticky error.
interface fifo_umbral_param_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
);
  logic              init;
  logic [ADDR_W:0]   limit_low;
  logic [ADDR_W:0]   limit_high;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;
  logic [ADDR_W:0]   fill_count;
  logic [2:0]        state;

  modport master (
    output init, limit_low, limit_high, push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, error, fill_count, state
  );

  modport slave (
    input  init, limit_low, limit_high, push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, error, fill_count, state
  );
endinterface

// File: rtl/fifo_umbral_param.sv
// Parametrised FIFO with run-time almost-full/almost-empty thresholds latched in INIT,
// sticky overflow/underflow error and a RESET/INIT/IDLE/ACTIVE/ERROR control FSM.
module fifo_umbral_param #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                reset,
  fifo_umbral_param_if.slave bus
);
  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LIM_HI_RST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_lim_lo;
  logic [ADDR_W:0]   r_lim_hi;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_error;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_err_set;
  logic              w_flush;

  assign w_full = (r_count == DEPTH_C);

  always_comb begin
    w_next_state = r_state;
    w_push_ok    = 1'b0;
    w_pop_ok     = 1'b0;
    w_err_set    = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_RESET: w_next_state = bus.init ? S_INIT : S_IDLE;
      S_INIT: begin
        w_flush = 1'b1;
        if (!bus.init) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        // Empty: a pop is an underflow even with a simultaneous push (no bypass).
        if (bus.init) begin
          w_next_state = S_INIT;
        end else if (bus.pop) begin
          w_err_set    = 1'b1;
          w_next_state = S_ERROR;
        end else if (bus.push) begin
          w_push_ok    = 1'b1;
          w_next_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.init) begin
          w_next_state = S_INIT;
        end else if (bus.push && !bus.pop && w_full) begin
          w_err_set    = 1'b1;
          w_next_state = S_ERROR;
        end else begin
          w_push_ok = bus.push;
          w_pop_ok  = bus.pop;
          if (bus.pop && !bus.push && (r_count == CNT_ONE)) w_next_state = S_IDLE;
        end
      end
      S_ERROR: if (bus.init) w_next_state = S_INIT;
      default: w_next_state = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
      r_lim_lo    <= CNT_ONE;
      r_lim_hi    <= LIM_HI_RST;
    end else begin
      r_valid_out <= w_pop_ok;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_error  <= 1'b0;
        r_lim_lo <= bus.limit_low;
        r_lim_hi <= bus.limit_high;
      end else begin
        if (w_err_set) r_error <= 1'b1;
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop_ok) begin
          // Reads the old word even when full and wr_ptr == rd_ptr in the same cycle.
          r_data_out <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        end
        if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_ONE;
        else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.data_in;
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.full         = w_full;
  assign bus.empty        = (r_count == '0);
  assign bus.almost_full  = (r_count >= r_lim_hi);
  assign bus.almost_empty = (r_count <= r_lim_lo);
  assign bus.error        = r_error;
  assign bus.fill_count   = r_count;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_fifo_umbral_param.sv
// Directed bench for fifo_umbral_param (DATA_W=10, DEPTH=8): vector table plus reset sequences.
module tb_fifo_umbral_param;
  localparam logic [2:0] S_RESET = 3'd0, S_INIT = 3'd1, S_IDLE = 3'd2, S_ACTIVE = 3'd3, S_ERROR = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_umbral_param_if #(.DATA_W(10), .ADDR_W(3)) bus ();
  fifo_umbral_param #(.DATA_W(10), .ADDR_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string      nm;
    logic       ini;
    logic [3:0] lo, hi;
    logic       psh, pp;
    logic [9:0] din;
    logic [2:0] st;
    logic [3:0] cnt;
    logic       full, empty, af, ae, err, vld;
    logic [9:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   t_lo, t_hi, m_lo, m_hi;
  logic [9:0] m_dout;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected flags come from the expected count and the thresholds the FIFO should hold.
  task automatic add(string nm, logic ini, logic psh, logic pp, logic [9:0] din,
                     logic [2:0] st, int cnt, logic err, logic vld);
    vec_t v;
    v.nm = nm; v.ini = ini; v.lo = 4'(t_lo); v.hi = 4'(t_hi);
    v.psh = psh; v.pp = pp; v.din = din; v.st = st; v.cnt = 4'(cnt);
    v.full = (cnt == 8); v.empty = (cnt == 0);
    v.af = (cnt >= m_hi); v.ae = (cnt <= m_lo);
    v.err = err; v.vld = vld; v.dout = m_dout;
    vecs.push_back(v);
  endtask

  task automatic drive(logic ini, logic [3:0] lo, logic [3:0] hi, logic psh, logic pp, logic [9:0] din);
    bus.init = ini; bus.limit_low = lo; bus.limit_high = hi;
    bus.push = psh; bus.pop = pp; bus.data_in = din;
  endtask

  task automatic check_outputs(string nm, logic [2:0] st, int cnt, logic full, logic empty,
                               logic af, logic ae, logic err, logic vld, logic [9:0] dout);
    chk({nm, ".state"}, 32'(bus.state), 32'(st));
    chk({nm, ".count"}, 32'(bus.fill_count), 32'(cnt));
    chk({nm, ".full"}, 32'(bus.full), 32'(full));
    chk({nm, ".empty"}, 32'(bus.empty), 32'(empty));
    chk({nm, ".almost_full"}, 32'(bus.almost_full), 32'(af));
    chk({nm, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    chk({nm, ".error"}, 32'(bus.error), 32'(err));
    chk({nm, ".valid_out"}, 32'(bus.valid_out), 32'(vld));
    chk({nm, ".data_out"}, 32'(bus.data_out), 32'(dout));
  endtask

  task automatic build_table();
    t_lo = 3; t_hi = 7; m_lo = 1; m_hi = 7; m_dout = '0;
    add("init_enter", 1, 0, 0, 10'h0, S_INIT, 0, 0, 0);
    m_lo = 3; m_hi = 7;
    add("init_exit", 0, 0, 0, 10'h0, S_IDLE, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("fill%0d", k), 0, 1, 0, 10'((k % 4) * 256 + 255), S_ACTIVE, k + 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      m_dout = 10'((k % 4) * 256 + 255);
      add($sformatf("drain%0d", k), 0, 0, 1, 10'h0, (k == 7) ? S_IDLE : S_ACTIVE, 7 - k, 0, 1);
    end
    add("idle_hold", 0, 0, 0, 10'h0, S_IDLE, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("fillb%0d", k), 0, 1, 0, 10'(10'h040 + k), S_ACTIVE, k + 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      m_dout = 10'(10'h040 + k);
      add($sformatf("wrap%0d", k), 0, 1, 1, 10'(10'h080 + k), S_ACTIVE, 8, 0, 1);
    end
    for (int k = 0; k < 8; k++) begin
      m_dout = (k < 4) ? 10'(10'h044 + k) : 10'(10'h080 + k - 4);
      add($sformatf("drainb%0d", k), 0, 0, 1, 10'h0, (k == 7) ? S_IDLE : S_ACTIVE, 7 - k, 0, 1);
    end
    for (int k = 0; k < 8; k++)
      add($sformatf("fillc%0d", k), 0, 1, 0, 10'(10'h100 + k), S_ACTIVE, k + 1, 0, 0);
    add("overflow", 0, 1, 0, 10'h3AA, S_ERROR, 8, 1, 0);
    add("err_pop", 0, 0, 1, 10'h0, S_ERROR, 8, 1, 0);
    add("err_push_pop", 0, 1, 1, 10'h155, S_ERROR, 8, 1, 0);
    t_lo = 5; t_hi = 2;
    add("err_to_init", 1, 0, 0, 10'h0, S_INIT, 8, 1, 0);
    m_lo = 5; m_hi = 2;
    add("init_exit_inv", 0, 0, 0, 10'h0, S_IDLE, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add($sformatf("inv_push%0d", k), 0, 1, 0, 10'(10'h155 + k), S_ACTIVE, k + 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      m_dout = 10'(10'h155 + k);
      add($sformatf("inv_pop%0d", k), 0, 0, 1, 10'h0, (k == 2) ? S_IDLE : S_ACTIVE, 2 - k, 0, 1);
    end
    add("underflow", 0, 1, 1, 10'h2AA, S_ERROR, 0, 1, 0);
    t_lo = 3; t_hi = 7;
    add("uf_to_init", 1, 0, 0, 10'h0, S_INIT, 0, 1, 0);
    m_lo = 3; m_hi = 7;
    add("uf_init_exit", 0, 0, 0, 10'h0, S_IDLE, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required to end before 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 4'd3, 4'd7, 0, 0, 10'h0);
    build_table();
    #1 reset = 1'b0;
    #1 check_outputs("reset_init", S_RESET, 0, 0, 1, 0, 1, 0, 0, 10'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ini, vecs[i].lo, vecs[i].hi, vecs[i].psh, vecs[i].pp, vecs[i].din);
      @(posedge clk);
      #1;
      check_outputs(vecs[i].nm, vecs[i].st, int'(vecs[i].cnt), vecs[i].full, vecs[i].empty,
                    vecs[i].af, vecs[i].ae, vecs[i].err, vecs[i].vld, vecs[i].dout);
    end

    // Reset asserted mid-operation with count 5 and a read in flight.
    for (int k = 0; k < 6; k++) begin
      drive(0, 4'd3, 4'd7, 1, 0, 10'(10'h2C0 + k));
      @(posedge clk);
      #1;
    end
    drive(0, 4'd3, 4'd7, 0, 1, 10'h0);
    @(posedge clk);
    #1;
    check_outputs("pre_reset", S_ACTIVE, 5, 0, 0, 0, 0, 0, 1, 10'h2C0);
    drive(0, 4'd3, 4'd7, 0, 0, 10'h0);
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", S_RESET, 0, 0, 1, 0, 1, 0, 0, 10'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("reset_exit", S_IDLE, 0, 0, 1, 0, 1, 0, 0, 10'h0);
    // Thresholds are back to lim_lo=1: almost_empty must drop at count 2.
    for (int k = 0; k < 2; k++) begin
      drive(0, 4'd3, 4'd7, 1, 0, 10'(10'h011 + k));
      @(posedge clk);
      #1;
    end
    check_outputs("rst_limits", S_ACTIVE, 2, 0, 0, 0, 0, 0, 0, 10'h0);
    drive(0, 4'd3, 4'd7, 0, 1, 10'h0);
    @(posedge clk);
    #1;
    check_outputs("rst_pop", S_ACTIVE, 1, 0, 0, 0, 1, 0, 1, 10'h011);
    drive(0, 4'd3, 4'd7, 0, 0, 10'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
